// File: rtl/match_pkg.sv
// Shared widths, FSM state encoding and result record for the match result collector.
package match_pkg;

  localparam int PAGE_W_DEF = 6;
  localparam int POS_W_DEF  = 15;
  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    REPORT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PAGE_W_DEF-1:0] page;
    logic [POS_W_DEF-1:0]  position;
  } result_t;

endpackage

// File: rtl/match_result_fifo.sv
// First-word-fall-through FIFO: head word and valid come straight from registered state.
module match_result_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     head_val,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_ok = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign head_val  = ~empty;
  assign level     = count_q;

endmodule

// File: rtl/match_result_collector.sv
// Tags match positions with the page number, buffers them, and reports the run total.
// Optional MATCH_DEDUP_EN discards a push equal to the last accepted entry of the run.
module match_result_collector
  import match_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PAGE_W = PAGE_W_DEF,
  parameter int POS_W  = POS_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [POS_W-1:0]          position,
  input  logic                      position_val,
  input  logic                      done,
  input  logic                      match_end,
  output logic [PAGE_W+POS_W-1:0]   res_data,
  output logic                      res_val,
  input  logic                      res_rdy,
  output logic [CNT_W-1:0]          total_cnt,
  output logic                      total_val,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  state_e                    state_q;
  logic [PAGE_W-1:0]         page_q;
  logic [CNT_W-1:0]          total_cnt_q;
  logic [CNT_W-1:0]          total_cnt_d;
  logic                      total_val_q;
  logic                      overflow_q;
  logic [PAGE_W+POS_W-1:0]   entry;
  logic                      dup;
  logic                      push_req;
  logic                      push_ok;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign entry       = {page_q, position};
  assign total_cnt_d = (&total_cnt_q) ? total_cnt_q : total_cnt_q + 1'b1;
  assign push_req    = (state_q == COLLECT) & position_val & ~dup;

`ifdef MATCH_DEDUP_EN
  logic [PAGE_W+POS_W-1:0] last_q;
  logic                    last_val_q;

  assign dup = last_val_q & (last_q == entry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      last_val_q <= 1'b0;
    end else if (state_q == REPORT) begin
      last_val_q <= 1'b0;
    end else if (push_ok) begin
      last_q     <= entry;
      last_val_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  match_result_fifo #(
    .DEPTH (DEPTH),
    .W     (PAGE_W + POS_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (entry),
    .pop       (res_rdy),
    .head_data (res_data),
    .head_val  (res_val),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      page_q      <= '0;
      total_cnt_q <= '0;
      total_val_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          // Dropped-on-full matches still count: the total reflects matches seen.
          if (push_req) begin
            total_cnt_q <= total_cnt_d;
            if (!push_ok) overflow_q <= 1'b1;
          end
          if (match_end)  state_q <= DRAIN;
          else if (done)  page_q  <= page_q + 1'b1;
        end
        DRAIN: begin
          if (position_val) overflow_q <= 1'b1;
          if (fifo_level == '0) begin
            state_q     <= REPORT;
            total_val_q <= 1'b1;
          end
        end
        REPORT: begin
          if (position_val) overflow_q <= 1'b1;
          total_val_q <= 1'b0;
          total_cnt_q <= '0;
          page_q      <= '0;
          state_q     <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign total_cnt = total_cnt_q;
  assign total_val = total_val_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_match_result_collector.sv
// Directed self-checking bench for match_result_collector (expectations follow MATCH_DEDUP_EN).
module tb_match_result_collector;
  import match_pkg::*;

  localparam int DEPTH  = 16;
  localparam int PAGE_W = 6;
  localparam int POS_W  = 15;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [POS_W-1:0]        position;
  logic                    position_val;
  logic                    done;
  logic                    match_end;
  logic [PAGE_W+POS_W-1:0] res_data;
  logic                    res_val;
  logic                    res_rdy;
  logic [CNT_W-1:0]        total_cnt;
  logic                    total_val;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  fifo_level;

  int tests  = 0;
  int failed = 0;

  match_result_collector #(
    .DEPTH (DEPTH), .PAGE_W (PAGE_W), .POS_W (POS_W), .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .position     (position),
    .position_val (position_val),
    .done         (done),
    .match_end    (match_end),
    .res_data     (res_data),
    .res_val      (res_val),
    .res_rdy      (res_rdy),
    .total_cnt    (total_cnt),
    .total_val    (total_val),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [PAGE_W+POS_W-1:0] ent(input int pg, input int ps);
    result_t r;
    r.page     = pg[PAGE_W-1:0];
    r.position = ps[POS_W-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ps);
    position     = ps[POS_W-1:0];
    position_val = 1'b1;
    step();
    position_val = 1'b0;
  endtask

  task automatic end_run();
    match_end = 1'b1;
    step();
    match_end = 1'b0;
  endtask

  // Bounded wait for the report pulse, then check the total and its clearing.
  task automatic wait_report(input string tag, input int exp_cnt);
    int n;
    n = 0;
    while (total_val !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_total_val"}, 32'(total_val), 32'd1);
    chk({tag, "_total_cnt"}, 32'(total_cnt), exp_cnt);
    step();
    chk({tag, "_total_val_low"}, 32'(total_val), 32'd0);
    chk({tag, "_total_cnt_clr"}, 32'(total_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; position = '0; position_val = 1'b0;
    done = 1'b0; match_end = 1'b0; res_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_val", 32'(res_val), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_total_val", 32'(total_val), 32'd0);
    chk("rst_total_cnt", 32'(total_cnt), 32'd0);
    rst = 1'b0;
    step();

    // Basic tagging across a page boundary
    res_rdy = 1'b1;
    strobe(5);
    chk("basic_val0", 32'(res_val), 32'd1);
    chk("basic_data0", 32'(res_data), 32'(ent(0, 5)));
    done = 1'b1; step(); done = 1'b0;
    chk("basic_popped", 32'(res_val), 32'd0);
    strobe(20);
    chk("basic_data1", 32'(res_data), 32'(ent(1, 20)));
    step();
    end_run();
    wait_report("basic", 2);

    // Full FIFO with backpressure: 18 strobes, 2 dropped but counted
    res_rdy = 1'b0;
    for (int i = 0; i < 18; i++) strobe(i);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_overflow", 32'(overflow), 32'd1);
    res_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_data%0d", i), 32'(res_data), 32'(ent(0, i)));
      step();
    end
    chk("full_empty", 32'(fifo_level), 32'd0);
    end_run();
    wait_report("full", 18);

    // Reset mid-run discards everything immediately
    res_rdy = 1'b0;
    strobe(1); strobe(2); strobe(3);
    chk("rstmid_level_pre", 32'(fifo_level), 32'd3);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_res_val", 32'(res_val), 32'd0);
    chk("rstmid_level", 32'(fifo_level), 32'd0);
    chk("rstmid_overflow", 32'(overflow), 32'd0);
    chk("rstmid_total_cnt", 32'(total_cnt), 32'd0);
    #1 rst = 1'b0;
    step();

    // Simultaneous position_val and done tag with the pre-increment page
    done = 1'b1;
    repeat (3) step();
    position = 15'd7; position_val = 1'b1;
    step();
    position_val = 1'b0; done = 1'b0;
    strobe(8);
    chk("simul_level", 32'(fifo_level), 32'd2);
    res_rdy = 1'b1;
    chk("simul_data0", 32'(res_data), 32'(ent(3, 7)));
    step();
    chk("simul_data1", 32'(res_data), 32'(ent(4, 8)));
    step();
    chk("simul_empty", 32'(fifo_level), 32'd0);
    res_rdy = 1'b0;

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 16; i++) strobe(100 + i);
    chk("pp_level_pre", 32'(fifo_level), 32'd16);
    position = 15'd200; position_val = 1'b1; res_rdy = 1'b1;
    step();
    position_val = 1'b0; res_rdy = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd16);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_head", 32'(res_data), 32'(ent(4, 101)));
    res_rdy = 1'b1;
    repeat (15) step();
    chk("pp_tail", 32'(res_data), 32'(ent(4, 200)));
    step();
    chk("pp_empty", 32'(fifo_level), 32'd0);
    res_rdy = 1'b0;

    // Drain with toggling res_rdy; a strobe during drain is dropped
    for (int i = 1; i <= 4; i++) strobe(i);
    chk("drain_level", 32'(fifo_level), 32'd4);
    end_run();
    for (int k = 0; k < 4; k++) begin
      res_rdy = 1'b0;
      if (k == 0) begin
        position = 15'd77; position_val = 1'b1;
      end
      step();
      position_val = 1'b0;
      chk($sformatf("drain_wait%0d", k), 32'(total_val), 32'd0);
      if (k == 0) chk("drain_overflow", 32'(overflow), 32'd1);
      res_rdy = 1'b1;
      step();
    end
    res_rdy = 1'b0;
    chk("drain_empty", 32'(fifo_level), 32'd0);
    chk("drain_no_early", 32'(total_val), 32'd0);
    wait_report("drain", 23);

    // Repeated position on page 0 after the report
    strobe(9); strobe(9);
`ifdef MATCH_DEDUP_EN
    chk("dedup_level", 32'(fifo_level), 32'd1);
`else
    chk("dedup_level", 32'(fifo_level), 32'd2);
`endif
    chk("dedup_head", 32'(res_data), 32'(ent(0, 9)));
    res_rdy = 1'b1;
    end_run();
`ifdef MATCH_DEDUP_EN
    wait_report("dedup", 1);
`else
    wait_report("dedup", 2);
`endif
    res_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/match_result_collector.md
Name: match_result_collector

Overview:
- Downstream stage of the string-match engine.
- Captures each match position pulse and tags it with the current page number (page advances on done).
- Buffers tagged results in a FIFO drained over a valid/ready interface.
- At match_end, flushes the FIFO, then reports the total match count for the run.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
PAGE_W, 6, page counter width
POS_W, 15, in-page position width (matches engine position output)
CNT_W, 16, total match counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
position  in  POS_W  match start offset within current page
position_val  in  1  one-cycle strobe, position valid
done  in  1  one-cycle strobe, current page finished
match_end  in  1  one-cycle strobe, whole run finished
res_data  out  PAGE_W+POS_W  {page, position} of head entry
res_val  out  1  head entry valid
res_rdy  in  1  consumer accepts head entry when res_val&res_rdy
total_cnt  out  CNT_W  matches pushed during the run
total_val  out  1  one-cycle strobe, total_cnt valid
overflow  out  1  sticky: a match was dropped
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: clk/rst as stated, rst asynchronous active-high; all outputs 0, FIFO empty, page=0, state COLLECT.
- FSM states COLLECT, DRAIN, REPORT.
- COLLECT: position_val pushes {page, position}, total_cnt+1 (saturating at all-ones). done: page+1, wraps modulo 2^PAGE_W. position_val and done in the same cycle: entry tagged with pre-increment page. match_end: go to DRAIN; a position_val in the same cycle is still pushed first.
- DRAIN: no pushes. position_val is dropped and sets overflow. Once fifo_level==0, go to REPORT.
- REPORT (one cycle): total_val=1 with the final total_cnt. Next cycle: total_cnt=0, page=0, overflow kept, state COLLECT.
- overflow clears only on rst.
- FIFO:
  - res_data/res_val are registered from the head (first-word-fall-through); latency push->res_val = 1 cycle.
  - Pop when res_val&res_rdy.
  - Full: push is accepted only if a pop occurs in the same cycle. Otherwise the entry is dropped, overflow=1, and total_cnt still counts it (total reflects matches seen).
  - Empty with simultaneous push and pop: no pop; entry appears next cycle.
  - res_data is stable while res_val&!res_rdy.
- fifo_level updates the cycle after a push/pop.
- done and match_end in the same cycle: page increment ignored (page clears at REPORT anyway).
- rst mid-run: FIFO contents discarded immediately.

Optional Feature:
- MATCH_DEDUP_EN defined: a push whose {page, position} equals the last accepted entry of the current run is discarded. It does not increment total_cnt and does not set overflow. The last-entry register clears at REPORT and on rst.
- Undefined: every position_val is pushed and counted.

Decomposition:
- Package match_pkg: PAGE_W/POS_W/CNT_W defaults, state encoding enum (COLLECT, DRAIN, REPORT), result struct {page, position}.
- One sub-module: match_result_fifo (synchronous FWFT FIFO with push/pop/full/empty/level).
- Counters and FSM live in the top module.

Test Plan:
- Basic: position_val at pos=5, done, position_val at pos=20, res_rdy=1 -> res_data {0,5} then {1,20}; match_end -> total_val pulse with total_cnt=2, then page=0.
- Backpressure/full with DEPTH=16, res_rdy=0: 18 strobes -> fifo_level=16, overflow=1, total_cnt=18. Raise res_rdy -> 16 entries in order, then match_end gives total_cnt=18.
- Simultaneous: position_val pos=7 with done at page 3 -> entry {3,7}, next entry page 4. Full FIFO with push and pop in the same cycle -> level stays 16, no overflow.
- Drain: match_end with 4 entries queued, res_rdy toggling -> total_val only after the 4th pop. A position_val during DRAIN -> dropped, overflow=1.
- Reset mid-run: 3 entries queued, assert rst -> res_val=0, fifo_level=0, overflow=0, page=0 the same cycle.
- MATCH_DEDUP_EN: two strobes pos=9 on page 0 -> one entry, total_cnt=1. Without the macro -> two entries, total_cnt=2.
